// File: rtl/mc_ctl_pkg.sv
// mc_ctl_pkg: state encodings, MIPS opcode/funct constants and datapath select codes
// shared by the multi-cycle control unit and its ALU control decoder.
package mc_ctl_pkg;

   typedef enum logic [3:0] {
      ST_FETCH   = 4'd0,
      ST_DECODE  = 4'd1,
      ST_MEM_ADR = 4'd2,
      ST_MEM_RD  = 4'd3,
      ST_MEM_WB  = 4'd4,
      ST_MEM_WR  = 4'd5,
      ST_EXEC    = 4'd6,
      ST_ALU_WB  = 4'd7,
      ST_BRANCH  = 4'd8,
      ST_JUMP    = 4'd9,
      ST_ADDI_EX = 4'd10,
      ST_ADDI_WB = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_NOR = 6'b100111;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   localparam logic [1:0] SRC_B_REG     = 2'b00;
   localparam logic [1:0] SRC_B_FOUR    = 2'b01;
   localparam logic [1:0] SRC_B_IMM     = 2'b10;
   localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control_unit_if.sv
// mc_control_unit_if: instruction-register inputs, ALU flag and all control outputs
// between the control unit (master) and the multi-cycle datapath (slave).
interface mc_control_unit_if;
   logic [5:0] Opcode;
   logic [5:0] Funct;
   logic       Zero_Flag;
   logic       PC_En;
   logic       IorD;
   logic       Mem_Read;
   logic       Mem_Write;
   logic       IR_Write;
   logic       Reg_Dst;
   logic       Mem_to_Reg;
   logic       Reg_Write;
   logic       ALU_Src_A;
   logic [1:0] ALU_Src_B;
   logic [3:0] ALU_Ctl;
   logic [1:0] PC_Src;
   logic       Illegal_Op;
   logic [3:0] State;

   modport master (
      input  Opcode, Funct, Zero_Flag,
      output PC_En, IorD, Mem_Read, Mem_Write, IR_Write, Reg_Dst, Mem_to_Reg,
             Reg_Write, ALU_Src_A, ALU_Src_B, ALU_Ctl, PC_Src, Illegal_Op, State
   );

   modport slave (
      output Opcode, Funct, Zero_Flag,
      input  PC_En, IorD, Mem_Read, Mem_Write, IR_Write, Reg_Dst, Mem_to_Reg,
             Reg_Write, ALU_Src_A, ALU_Src_B, ALU_Ctl, PC_Src, Illegal_Op, State
   );
endinterface

// File: rtl/mc_control_unit_alu_ctl_decode.sv
// alu_ctl_decode: R-type funct field to 4-bit ALU operation; valid is low for
// unsupported funct codes, in which case ADD is returned.
module alu_ctl_decode
   import mc_ctl_pkg::*;
(
   input  logic [5:0] funct,
   output logic [3:0] alu_ctl,
   output logic       valid
);
   always_comb begin
      alu_ctl = ALU_ADD;
      valid   = 1'b1;
      case (funct)
         FN_ADD:  alu_ctl = ALU_ADD;
         FN_SUB:  alu_ctl = ALU_SUB;
         FN_AND:  alu_ctl = ALU_AND;
         FN_OR:   alu_ctl = ALU_OR;
         FN_SLT:  alu_ctl = ALU_SLT;
         FN_NOR:  alu_ctl = ALU_NOR;
         default: valid   = 1'b0;
      endcase
   end
endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: Moore FSM sequencing MIPS instructions fetch..writeback.
// Define ADDI_EN to add the addi execute/writeback states.
module mc_control_unit
   import mc_ctl_pkg::*;
(
   input  logic              Clk,
   input  logic              Rst_n,
   mc_control_unit_if.master ctl
);
   state_t     state;
   state_t     state_nxt;
   logic       is_lw;
   logic [3:0] exec_alu_ctl;
   logic       exec_valid;
   logic       illegal;

   logic       pc_en;
   logic       iord;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [3:0] alu_ctl;
   logic [1:0] pc_src;

   alu_ctl_decode u_alu_ctl_decode (
      .funct   (ctl.Funct),
      .alu_ctl (exec_alu_ctl),
      .valid   (exec_valid)
   );

   // The lw/sw choice is captured in DECODE so MEM_ADR no longer depends on Opcode.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state <= ST_FETCH;
         is_lw <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == ST_DECODE)
            is_lw <= (ctl.Opcode == OP_LW);
      end
   end

   always_comb begin
      state_nxt = ST_FETCH;
      illegal   = 1'b0;
      case (state)
         ST_FETCH:   state_nxt = ST_DECODE;
         ST_DECODE: begin
            case (ctl.Opcode)
               OP_LW, OP_SW: state_nxt = ST_MEM_ADR;
               OP_RTYPE:     state_nxt = ST_EXEC;
               OP_BEQ:       state_nxt = ST_BRANCH;
               OP_J:         state_nxt = ST_JUMP;
`ifdef ADDI_EN
               OP_ADDI:      state_nxt = ST_ADDI_EX;
`endif
               default:      illegal   = 1'b1;
            endcase
         end
         ST_MEM_ADR: state_nxt = is_lw ? ST_MEM_RD : ST_MEM_WR;
         ST_MEM_RD:  state_nxt = ST_MEM_WB;
         ST_EXEC: begin
            if (exec_valid)
               state_nxt = ST_ALU_WB;
            else
               illegal   = 1'b1;
         end
`ifdef ADDI_EN
         ST_ADDI_EX: state_nxt = ST_ADDI_WB;
`endif
         default:    state_nxt = ST_FETCH;
      endcase
   end

   always_comb begin
      pc_en      = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRC_B_REG;
      alu_ctl    = ALU_ADD;
      pc_src     = PC_SRC_ALU;
      case (state)
         ST_FETCH: begin
            mem_read  = 1'b1;
            ir_write  = 1'b1;
            alu_src_b = SRC_B_FOUR;
            pc_en     = 1'b1;
         end
         ST_DECODE:  alu_src_b = SRC_B_IMM_SH2;
         ST_MEM_ADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRC_B_IMM;
         end
         ST_MEM_RD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         ST_MEM_WB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
         end
         ST_MEM_WR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
         end
         ST_EXEC: begin
            alu_src_a = 1'b1;
            alu_ctl   = exec_alu_ctl;
         end
         ST_ALU_WB: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
         end
         // Zero_Flag is 1 when the difference is nonzero, so the branch is taken on 0.
         ST_BRANCH: begin
            alu_src_a = 1'b1;
            alu_ctl   = ALU_SUB;
            pc_src    = PC_SRC_ALUOUT;
            pc_en     = ~ctl.Zero_Flag;
         end
         ST_JUMP: begin
            pc_src = PC_SRC_JUMP;
            pc_en  = 1'b1;
         end
`ifdef ADDI_EN
         ST_ADDI_EX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRC_B_IMM;
         end
         ST_ADDI_WB: reg_write = 1'b1;
`endif
         default: ;
      endcase
   end

   // Architectural write strobes are held off for as long as reset is asserted.
   assign ctl.PC_En      = pc_en & Rst_n;
   assign ctl.IR_Write   = ir_write & Rst_n;
   assign ctl.Mem_Write  = mem_write & Rst_n;
   assign ctl.Reg_Write  = reg_write & Rst_n;
   assign ctl.IorD       = iord;
   assign ctl.Mem_Read   = mem_read;
   assign ctl.Reg_Dst    = reg_dst;
   assign ctl.Mem_to_Reg = mem_to_reg;
   assign ctl.ALU_Src_A  = alu_src_a;
   assign ctl.ALU_Src_B  = alu_src_b;
   assign ctl.ALU_Ctl    = alu_ctl;
   assign ctl.PC_Src     = pc_src;
   assign ctl.Illegal_Op = illegal;
   assign ctl.State      = state;

endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: directed cycle-by-cycle check of the complete output vector
// of mc_control_unit for every instruction class, reset and illegal encodings.
module tb_mc_control_unit;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   errors = 0;

   mc_control_unit_if bus ();

   mc_control_unit dut (
      .Clk   (clk),
      .Rst_n (rst_n),
      .ctl   (bus)
   );

   always #5 clk = ~clk;

   // {State, PC_En, IorD, Mem_Read, Mem_Write, IR_Write, Reg_Dst, Mem_to_Reg,
   //  Reg_Write, ALU_Src_A, ALU_Src_B, ALU_Ctl, PC_Src, Illegal_Op}
   function automatic logic [21:0] mk(input logic [3:0] st, input logic pce, input logic iord,
                                      input logic mrd, input logic mwr, input logic irw,
                                      input logic rdst, input logic m2r, input logic rw,
                                      input logic sa, input logic [1:0] sb, input logic [3:0] alu,
                                      input logic [1:0] pcs, input logic ill);
      return {st, pce, iord, mrd, mwr, irw, rdst, m2r, rw, sa, sb, alu, pcs, ill};
   endfunction

   function automatic logic [21:0] observed();
      return {bus.State, bus.PC_En, bus.IorD, bus.Mem_Read, bus.Mem_Write, bus.IR_Write,
              bus.Reg_Dst, bus.Mem_to_Reg, bus.Reg_Write, bus.ALU_Src_A, bus.ALU_Src_B,
              bus.ALU_Ctl, bus.PC_Src, bus.Illegal_Op};
   endfunction

   task automatic chk(input string tag, input logic [21:0] exp);
      logic [21:0] obs;
      obs = observed();
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%06h expected=%06h", tag, obs, exp);
      end
   endtask

   task automatic nc();
      @(negedge clk);
   endtask

   logic [21:0] v_rst, v_fetch, v_decode, v_decode_ill, v_mem_adr, v_mem_rd, v_mem_wb;
   logic [21:0] v_mem_wr, v_alu_wb, v_jump, v_addi_ex, v_addi_wb;

   task automatic do_rtype(input logic [5:0] funct, input logic [3:0] alu, input logic ok);
      bus.Opcode = 6'b000000;
      bus.Funct  = funct;
      nc(); chk($sformatf("r%02h.decode", funct), v_decode);
      bus.Funct = 6'b111111;  // Funct is only looked at during EXEC
      nc(); bus.Funct = funct; #1;
      chk($sformatf("r%02h.exec", funct), mk(4'd6,0,0,0,0,0,0,0,0,1,2'b00,alu,2'b00,!ok));
      if (ok) begin
         nc(); chk($sformatf("r%02h.alu_wb", funct), v_alu_wb);
      end
      nc(); chk($sformatf("r%02h.fetch", funct), v_fetch);
   endtask

   task automatic do_beq(input logic zf);
      bus.Opcode    = 6'b000100;
      bus.Zero_Flag = zf;
      nc(); chk($sformatf("beq%0d.decode", zf), v_decode);
      nc(); chk($sformatf("beq%0d.branch", zf), mk(4'd8,!zf,0,0,0,0,0,0,0,1,2'b00,4'b0110,2'b01,0));
      nc(); chk($sformatf("beq%0d.fetch", zf), v_fetch);
   endtask

   initial begin
      v_rst        = mk(4'd0, 0,0,1,0,0,0,0,0,0,2'b01,4'b0010,2'b00,0);
      v_fetch      = mk(4'd0, 1,0,1,0,1,0,0,0,0,2'b01,4'b0010,2'b00,0);
      v_decode     = mk(4'd1, 0,0,0,0,0,0,0,0,0,2'b11,4'b0010,2'b00,0);
      v_decode_ill = mk(4'd1, 0,0,0,0,0,0,0,0,0,2'b11,4'b0010,2'b00,1);
      v_mem_adr    = mk(4'd2, 0,0,0,0,0,0,0,0,1,2'b10,4'b0010,2'b00,0);
      v_mem_rd     = mk(4'd3, 0,1,1,0,0,0,0,0,0,2'b00,4'b0010,2'b00,0);
      v_mem_wb     = mk(4'd4, 0,0,0,0,0,0,1,1,0,2'b00,4'b0010,2'b00,0);
      v_mem_wr     = mk(4'd5, 0,1,0,1,0,0,0,0,0,2'b00,4'b0010,2'b00,0);
      v_alu_wb     = mk(4'd7, 0,0,0,0,0,1,0,1,0,2'b00,4'b0010,2'b00,0);
      v_jump       = mk(4'd9, 1,0,0,0,0,0,0,0,0,2'b00,4'b0010,2'b10,0);
      v_addi_ex    = mk(4'd10,0,0,0,0,0,0,0,0,1,2'b10,4'b0010,2'b00,0);
      v_addi_wb    = mk(4'd11,0,0,0,0,0,0,0,1,0,2'b00,4'b0010,2'b00,0);

      bus.Opcode    = 6'b100011;
      bus.Funct     = 6'b000000;
      bus.Zero_Flag = 1'b1;

      // Reset asserted before any clock edge, then held across edges
      #1 rst_n = 1'b0;
      #2 chk("reset.async", v_rst);
      nc(); nc(); chk("reset.hold", v_rst);

      // lw: 0,1,2,3,4,0 ; Opcode changed in MEM_ADR must not turn it into sw
      rst_n = 1'b1; #1;
      chk("lw.fetch", v_fetch);
      nc(); chk("lw.decode", v_decode);
      nc(); chk("lw.mem_adr", v_mem_adr);
      bus.Opcode = 6'b101011;
      nc(); chk("lw.mem_rd", v_mem_rd);
      nc(); chk("lw.mem_wb", v_mem_wb);
      nc(); chk("lw.fetch_end", v_fetch);

      // sw: 0,1,2,5,0
      bus.Opcode = 6'b101011;
      nc(); chk("sw.decode", v_decode);
      nc(); chk("sw.mem_adr", v_mem_adr);
      nc(); chk("sw.mem_wr", v_mem_wr);
      nc(); chk("sw.fetch", v_fetch);

      // R-type, all six supported funct codes plus one unsupported
      do_rtype(6'b100000, 4'b0010, 1'b1);
      do_rtype(6'b100010, 4'b0110, 1'b1);
      do_rtype(6'b100100, 4'b0000, 1'b1);
      do_rtype(6'b100101, 4'b0001, 1'b1);
      do_rtype(6'b101010, 4'b0111, 1'b1);
      do_rtype(6'b100111, 4'b1100, 1'b1);
      do_rtype(6'b000000, 4'b0010, 1'b0);

      // beq taken and not taken
      do_beq(1'b0);
      do_beq(1'b1);

      // j
      bus.Opcode = 6'b000010;
      nc(); chk("j.decode", v_decode);
      nc(); chk("j.jump", v_jump);
      nc(); chk("j.fetch", v_fetch);

      // Illegal opcode
      bus.Opcode = 6'b111111;
      nc(); chk("ill.decode", v_decode_ill);
      nc(); chk("ill.fetch", v_fetch);

      // addi
      bus.Opcode = 6'b001000;
      nc();
`ifdef ADDI_EN
      chk("addi.decode", v_decode);
      nc(); chk("addi.ex", v_addi_ex);
      nc(); chk("addi.wb", v_addi_wb);
`else
      chk("addi.decode", v_decode_ill);
`endif
      nc(); chk("addi.fetch", v_fetch);

      // Reset in the middle of MEM_RD, then resume with a full lw
      bus.Opcode = 6'b100011;
      nc(); chk("rlw.decode", v_decode);
      nc(); chk("rlw.mem_adr", v_mem_adr);
      nc(); chk("rlw.mem_rd", v_mem_rd);
      #2 rst_n = 1'b0;
      #1 chk("rlw.reset_async", v_rst);
      nc(); chk("rlw.reset_hold", v_rst);
      nc(); chk("rlw.reset_hold2", v_rst);
      rst_n = 1'b1; #1;
      chk("rlw.fetch", v_fetch);
      nc(); chk("rlw.decode2", v_decode);
      nc(); chk("rlw.mem_adr2", v_mem_adr);
      nc(); chk("rlw.mem_rd2", v_mem_rd);
      nc(); chk("rlw.mem_wb", v_mem_wb);
      nc(); chk("rlw.fetch_end", v_fetch);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle MIPS control unit: the issuing side of the ALU control interface. It sequences each instruction through fetch, decode, execute, memory and writeback states. Each cycle it drives the 4-bit ALU operation code, the ALU operand selects and all datapath strobes. It consumes the ALU's zero flag to resolve branches, and sits between the instruction register and the multi-cycle datapath.

## Interface
Parameters: none. Widths are fixed by the ISA.

Ports:
- Clk  in  1  single clock, rising edge
- Rst_n  in  1  asynchronous, active-low reset
- Opcode  in  6  instruction bits [31:26] from the instruction register
- Funct  in  6  instruction bits [5:0] from the instruction register
- Zero_Flag  in  1  ALU flag: 1 = ALU result nonzero, 0 = ALU result zero
- PC_En  out  1  PC load enable
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- Mem_Read  out  1  memory read strobe
- Mem_Write  out  1  memory write strobe
- IR_Write  out  1  instruction register load
- Reg_Dst  out  1  write register select: 0 = rt, 1 = rd
- Mem_to_Reg  out  1  writeback data select: 0 = ALUOut, 1 = MDR
- Reg_Write  out  1  register file write
- ALU_Src_A  out  1  operand A select: 0 = PC, 1 = A register
- ALU_Src_B  out  2  operand B select: 00 = B register, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- ALU_Ctl  out  4  ALU op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
- PC_Src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- Illegal_Op  out  1  one-cycle pulse on an unsupported opcode or funct
- State  out  4  current state, for debug

## Operation
**State machine.** Moore FSM with a 4-bit state register. Outputs are decoded from the state; the only exceptions are ALU_Ctl in EXEC (which also depends on Funct) and PC_En in BRANCH (which also depends on Zero_Flag).

**Defaults.** Any output not listed for a state takes: strobes 0, selects 0, ALU_Ctl = 0010.

**States and outputs:**
- FETCH (0): Mem_Read = 1, IR_Write = 1, ALU_Src_B = 01, ALU_Ctl = ADD, PC_En = 1. Next: DECODE.
- DECODE (1): ALU_Src_B = 11, ALU_Ctl = ADD (branch target to ALUOut). Next state by Opcode:
  - lw 100011 or sw 101011 → MEM_ADR
  - R-type 000000 → EXEC
  - beq 000100 → BRANCH
  - j 000010 → JUMP
  - addi 001000 → ADDI_EX (only when the macro is enabled)
  - anything else → FETCH, with Illegal_Op = 1
- MEM_ADR (2): ALU_Src_A = 1, ALU_Src_B = 10, ADD. Next: MEM_RD for lw, MEM_WR for sw.
- MEM_RD (3): Mem_Read = 1, IorD = 1. Next: MEM_WB.
- MEM_WB (4): Mem_to_Reg = 1, Reg_Write = 1, Reg_Dst = 0. Next: FETCH.
- MEM_WR (5): Mem_Write = 1, IorD = 1. Next: FETCH.
- EXEC (6): ALU_Src_A = 1, ALU_Src_B = 00, ALU_Ctl from Funct:
  - 100000 → 0010
  - 100010 → 0110
  - 100100 → 0000
  - 100101 → 0001
  - 101010 → 0111
  - 100111 → 1100
  - Next: ALU_WB for a supported Funct. An unsupported Funct drives ALU_Ctl = 0010, pulses Illegal_Op, and goes to FETCH without writeback.
- ALU_WB (7): Reg_Dst = 1, Reg_Write = 1. Next: FETCH.
- BRANCH (8): ALU_Src_A = 1, SUB, PC_Src = 01, PC_En = ~Zero_Flag (taken when operands are equal). Next: FETCH.
- JUMP (9): PC_Src = 10, PC_En = 1. Next: FETCH.
- Encodings 10–15 with no assigned state: next state FETCH, outputs at defaults.

## Timing
- **Reset.** While Rst_n = 0, State = FETCH. PC_En, IR_Write, Mem_Write and Reg_Write are forced to 0; every other output holds its FETCH value.
- **After reset.** On the first rising edge after Rst_n deasserts, the machine moves to DECODE. The preceding cycle, with Rst_n already high, is the first real fetch.
- **Reset mid-instruction.** The state returns to FETCH immediately and asynchronously. No partial writeback strobe is asserted afterwards.
- **Latency** (cycles from FETCH back to FETCH):
  - R-type 4, lw 5, sw 4, beq 3, j 3, addi 4
- **Sampling.** Opcode and Funct are sampled only in DECODE and EXEC. Zero_Flag is sampled only in BRANCH and must be settled before the rising edge that ends BRANCH.

## Configuration
- **ADDI_EN defined:**
  - DECODE routes opcode 001000 to ADDI_EX (10).
  - ADDI_EX: ALU_Src_A = 1, ALU_Src_B = 10, ADD. Next: ADDI_WB.
  - ADDI_WB (11): Reg_Dst = 0, Reg_Write = 1, Mem_to_Reg = 0. Next: FETCH.
- **ADDI_EN undefined:** opcode 001000 is illegal (Illegal_Op pulse, return to FETCH), and encodings 10–11 behave as unused.

## Structure
- **Package mc_ctl_pkg** holds:
  - state encodings
  - opcode constants
  - funct constants
  - ALU_Ctl codes, matching the ALU truth table exactly
  - ALU_Src_B and PC_Src select constants
- **Sub-module alu_ctl_decode** (combinational): Funct → ALU_Ctl plus a valid bit. Used in EXEC.

## Test plan
- **Reset:** Rst_n low mid-MEM_RD → State = 0 at once; PC_En = IR_Write = Mem_Write = Reg_Write = 0. Release → DECODE on the next edge.
- **lw:** Opcode 100011 → states 0,1,2,3,4,0. Mem_Read in 0 and 3, IorD = 1 in 3, Reg_Write = 1 only in 4.
- **R-type:** Opcode 0, each of the 6 Funct codes → correct ALU_Ctl in EXEC; Reg_Write in ALU_WB with Reg_Dst = 1. Funct 000000 → Illegal_Op pulse, no Reg_Write, back to FETCH.
- **beq:** Zero_Flag = 0 → PC_En = 1, PC_Src = 01. Zero_Flag = 1 → PC_En = 0. Both cases take 3 cycles.
- **j / sw:** j → PC_Src = 10, PC_En = 1 in JUMP. sw → Mem_Write = 1 in state 5 only.
- **Illegal opcode / addi:** Opcode 111111 → Illegal_Op in DECODE, then FETCH. Opcode 001000 → Illegal_Op with ADDI_EN undefined; states 10, 11 with Reg_Write = 1 when ADDI_EN is defined.
